// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state codes,
// fetch error codes, data width and an alignment helper.
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  localparam logic [1:0] FERR_NONE     = 2'b00;
  localparam logic [1:0] FERR_MISALIGN = 2'b01;
  localparam logic [1:0] FERR_TIMEOUT  = 2'b10;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/ack side plus decode valid/ready side.
// Handshakes: imem - the request is held until imem_ack is seen while imem_req=1;
// decode - a transfer happens on a rising edge where instr_valid=1 and instr_ready=1.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ack;

  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PCPlus4;
  logic            instr_valid;
  logic            instr_ready;

  logic            PCSrc;
  logic            Jalr;
  logic [XLEN-1:0] PCTarget;
  logic [XLEN-1:0] ALUResult;

  logic [1:0]      fetch_err;

  modport master (
    output imem_req, imem_addr, Instr, PC, PCPlus4, instr_valid, fetch_err,
    input  imem_rdata, imem_ack, instr_ready, PCSrc, Jalr, PCTarget, ALUResult
  );

  modport slave (
    input  imem_req, imem_addr, Instr, PC, PCPlus4, instr_valid, fetch_err,
    output imem_rdata, imem_ack, instr_ready, PCSrc, Jalr, PCTarget, ALUResult
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Next-PC target mux (JALR over branch/JAL over sequential) with a
// word-alignment check on the selected target.
module instr_fetch_unit_next_pc_sel
  import instr_fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  input  logic            pc_src,
  input  logic            jalr,
  output logic [XLEN-1:0] npc,
  output logic            misaligned
);

  always_comb begin
    npc = pc_plus4;
    if (jalr) begin
      // JALR clears bit 0 of the computed address before use.
      npc = alu_result & ~32'd1;
    end else if (pc_src) begin
      npc = pc_target;
    end
  end

  assign misaligned = !is_aligned(npc);

endmodule

// File: rtl/instr_fetch_unit.sv
// Non-speculative fetch stage: one instruction in flight, fetched over
// req/ack and handed to decode over valid/ready; errors are sticky until reset.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_fetch_unit_if.master  bus,
  output logic [1:0]          fsm_state
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]      state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [7:0]      wait_cnt;
  logic [1:0]      err_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] npc;
  logic            npc_misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  instr_fetch_unit_next_pc_sel u_next_pc_sel (
    .pc_plus4   (pc_plus4),
    .pc_target  (bus.PCTarget),
    .alu_result (bus.ALUResult),
    .pc_src     (bus.PCSrc),
    .jalr       (bus.Jalr),
    .npc        (npc),
    .misaligned (npc_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_ISSUE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      wait_cnt <= '0;
      err_q    <= FERR_NONE;
    end else begin
      case (state)
        ST_ISSUE: begin
          // An ack in the timeout cycle still wins over the error.
          if (bus.imem_ack) begin
            instr_q  <= bus.imem_rdata;
            wait_cnt <= '0;
            state    <= ST_HOLD;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            err_q <= FERR_TIMEOUT;
            state <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (bus.instr_ready) begin
            pc_q <= npc;
            if (npc_misaligned) begin
              err_q <= FERR_MISALIGN;
              state <= ST_ERR;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        default: state <= ST_ERR;
      endcase
    end
  end

  assign bus.imem_req    = (state == ST_ISSUE);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state == ST_HOLD);
  assign bus.Instr       = instr_q;
  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.fetch_err   = err_q;
  assign fsm_state       = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed fetch/redirect/error/reset
// scenarios followed by randomized transactions against a transaction-level model.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int          T       = 12;
  localparam logic [31:0] RPC     = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if wbus ();
  logic [1:0] st;
  logic [1:0] wst;

  instr_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .fsm_state(st)
  );

  instr_fetch_unit #(.RESET_PC(WRAP_PC), .TIMEOUT(T)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .bus(wbus), .fsm_state(wst)
  );

  // Second instance runs on an always-ready, zero-wait, no-redirect environment.
  initial begin
    wbus.imem_ack    = 1'b1;
    wbus.imem_rdata  = 32'h0000_0013;
    wbus.instr_ready = 1'b1;
    wbus.PCSrc       = 1'b0;
    wbus.Jalr        = 1'b0;
    wbus.PCTarget    = 32'h0;
    wbus.ALUResult   = 32'h0;
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic src,
                                            input logic jr, input logic [31:0] tgt,
                                            input logic [31:0] alu);
    if (jr) return {alu[31:1], 1'b0};
    if (src) return tgt;
    return pc + 32'd4;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = $urandom;
    bus.instr_ready = 1'b0;
    bus.PCSrc       = 1'($urandom_range(0, 1));
    bus.Jalr        = 1'($urandom_range(0, 1));
    bus.PCTarget    = $urandom;
    bus.ALUResult   = $urandom;
  endtask

  // Holds reset for n rising edges; inputs set by the caller stay applied meanwhile.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    exp_q.delete();
    exp_q.push_back(RPC);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_err", bus.fetch_err, FERR_NONE);
    chk("rst_instr", bus.Instr, 0);
    chk("rst_req", bus.imem_req, 1);
    chk("rst_addr", bus.imem_addr, RPC);
  endtask

  // One complete transaction: request, ack after ack_dly cycles, hold for rdy_dly cycles, accept.
  task automatic fetch_one(input int ack_dly, input int rdy_dly, input logic src,
                           input logic jr, input logic [31:0] tgt, input logic [31:0] alu,
                           output logic errd);
    logic [31:0] pc;
    logic [31:0] npc;
    errd = 1'b0;
    if (exp_q.size() == 0) begin
      chk("model_queue_empty", 0, 1);
      return;
    end
    pc = exp_q.pop_front();
    for (int i = 0; i <= ack_dly; i++) begin
      chk("issue_req", bus.imem_req, 1);
      chk("issue_addr", bus.imem_addr, pc);
      chk("issue_valid", bus.instr_valid, 0);
      idle_inputs();
      if (i == ack_dly) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(pc);
      end
      tick();
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("hold_valid", bus.instr_valid, 1);
      chk("hold_req", bus.imem_req, 0);
      chk("hold_instr", bus.Instr, mem_word(pc));
      chk("hold_pc", bus.PC, pc);
      chk("hold_pcplus4", bus.PCPlus4, pc + 32'd4);
      idle_inputs();
      bus.imem_ack = 1'($urandom_range(0, 1));
      if (i == rdy_dly) begin
        bus.instr_ready = 1'b1;
        bus.PCSrc       = src;
        bus.Jalr        = jr;
        bus.PCTarget    = tgt;
        bus.ALUResult   = alu;
      end
      tick();
    end
    idle_inputs();
    npc = model_npc(pc, src, jr, tgt, alu);
    chk("post_accept_valid", bus.instr_valid, 0);
    if (npc % 4 != 0) begin
      chk("misalign_err", bus.fetch_err, FERR_MISALIGN);
      chk("misalign_req", bus.imem_req, 0);
      chk("misalign_pc", bus.PC, npc);
      errd = 1'b1;
    end else begin
      chk("no_err", bus.fetch_err, FERR_NONE);
      exp_q.push_back(npc);
    end
  endtask

  task automatic err_sticky(input logic [1:0] code, input logic [31:0] pc, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      idle_inputs();
      bus.imem_ack    = 1'($urandom_range(0, 1));
      bus.instr_ready = 1'($urandom_range(0, 1));
      tick();
      chk("err_req", bus.imem_req, 0);
      chk("err_valid", bus.instr_valid, 0);
      chk("err_code", bus.fetch_err, code);
      chk("err_pc", bus.PC, pc);
      chk("err_state", st, ST_ERR);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic errd;
    idle_inputs();
    @(negedge clk);

    // Reset and sequential zero-wait fetch; also the wrap instance.
    do_reset(2);
    chk("wrap_first_addr", wbus.imem_addr, WRAP_PC);
    chk("wrap_first_req", wbus.imem_req, 1);
    chk("wrap_pcplus4", wbus.PCPlus4, 32'h0);
    chk("wrap_state", wst, ST_ISSUE);
    fetch_one(0, 0, 0, 0, 0, 0, errd);
    chk("wrap_next_addr", wbus.imem_addr, 32'h0);
    chk("wrap_next_req", wbus.imem_req, 1);
    chk("wrap_err", wbus.fetch_err, FERR_NONE);
    fetch_one(0, 0, 0, 0, 0, 0, errd);
    fetch_one(0, 0, 0, 0, 0, 0, errd);

    // Wait states and backpressure at 0xC.
    fetch_one(3, 4, 0, 0, 0, 0, errd);

    // Redirects at 0x10.
    fetch_one(0, 0, 1, 0, 32'h40, 0, errd);
    fetch_one(1, 1, 1, 0, 32'h10, 0, errd);
    fetch_one(0, 0, 0, 1, 32'h44, 32'h81, errd);
    fetch_one(0, 0, 0, 1, 32'h44, 32'h11, errd);
    fetch_one(2, 0, 1, 1, 32'h40, 32'h101, errd);
    // Ack in the last allowed wait cycle still completes; then wrap through 0xFFFF_FFFC.
    fetch_one(T, 0, 1, 0, 32'hFFFF_FFFC, 0, errd);
    fetch_one(0, 1, 0, 0, 0, 0, errd);
    fetch_one(0, 0, 0, 0, 0, 0, errd);

    // Misaligned branch target.
    fetch_one(0, 0, 1, 0, 32'h42, 0, errd);
    err_sticky(FERR_MISALIGN, 32'h42, 8);

    // Imem timeout.
    idle_inputs();
    do_reset(1);
    for (int i = 0; i <= T; i++) begin
      chk("to_req", bus.imem_req, 1);
      chk("to_addr", bus.imem_addr, RPC);
      idle_inputs();
      tick();
    end
    chk("to_err", bus.fetch_err, FERR_TIMEOUT);
    err_sticky(FERR_TIMEOUT, RPC, 8);

    // Reset during ISSUE with an ack in the reset cycle.
    idle_inputs();
    do_reset(1);
    fetch_one(0, 0, 0, 0, 0, 0, errd);
    chk("pre_rst_addr", bus.imem_addr, 32'h4);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    do_reset(1);
    tick();
    chk("rst_ack_dropped_valid", bus.instr_valid, 0);
    chk("rst_ack_dropped_req", bus.imem_req, 1);
    chk("rst_ack_dropped_addr", bus.imem_addr, RPC);
    fetch_one(0, 0, 0, 0, 0, 0, errd);

    // Reset during HOLD drops the presented instruction.
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = mem_word(32'h4);
    tick();
    chk("hold_before_rst", bus.instr_valid, 1);
    idle_inputs();
    do_reset(1);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [31:0] tgt;
      logic [31:0] alu;
      kind = $urandom_range(0, 9);
      tgt = $urandom & 32'hFFFF_FFFC;
      alu = $urandom & 32'hFFFF_FFFD;
      if (kind <= 3) begin
        fetch_one($urandom_range(0, 4), $urandom_range(0, 3), 0, 0, $urandom, $urandom, errd);
      end else if (kind <= 5) begin
        fetch_one($urandom_range(0, 4), $urandom_range(0, 3), 1, 0, tgt, $urandom, errd);
      end else if (kind <= 7) begin
        fetch_one($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1,
                  $urandom, alu, errd);
      end else if (kind == 8) begin
        fetch_one($urandom_range(0, 2), $urandom_range(0, 2), 0, 1, 0, alu | 32'h2, errd);
      end else begin
        fetch_one($urandom_range(0, 2), $urandom_range(0, 2), 1, 0, tgt | 32'h1, 0, errd);
      end
      if (errd) begin
        err_sticky(FERR_MISALIGN, bus.PC, 2);
        idle_inputs();
        do_reset(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
